// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit unsigned multiply (shift-add) / divide (restoring) unit.
// Latency: START accepted at edge k -> BUSY after edges k..k+WIDTH-1 -> DONE after edge k+WIDTH.
// Backpressure: none; START is honoured only in IDLE/DONE and dropped while BUSY.
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   START, OP[1:0]       request and operation (00 MUL_LO, 01 MUL_HI, 10 DIV_Q, 11 DIV_R)
//   DATA1, DATA2         multiplicand/dividend, multiplier/divisor (latched on accept)
//   RESULT, DIVZERO      result and divide-by-zero flag, updated on the CALC->DONE edge
//   BUSY, DONE           CALC state indicator, one-cycle completion pulse
module mul_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIVZERO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [1:0]       op_q,      op_d;
  // acc: product high half (multiply) or remainder with guard bit (divide).
  logic [WIDTH:0]   acc_q,     acc_d;
  // lo: multiplier shifting out / product low half, or dividend shifting out / quotient.
  logic [WIDTH-1:0] lo_q,      lo_d;
  // opd: multiplicand (multiply) or divisor (divide).
  logic [WIDTH-1:0] opd_q,     opd_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] lo_step;

  // One iteration of the selected algorithm on the current register contents.
  always_comb begin
    sum      = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shifted  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    acc_step = acc_q;
    lo_step  = lo_q;
    if (op_q[1]) begin
      // Restoring divide: a zero divisor always subtracts, giving all-ones
      // quotient and remainder equal to the dividend without special casing.
      if (shifted >= {1'b0, opd_q}) begin
        acc_step = shifted - {1'b0, opd_q};
        lo_step  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = shifted;
        lo_step  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Right-shift shift-add: the carry out of the add drops into the high half.
      acc_step = {1'b0, sum[WIDTH:1]};
      lo_step  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    result_d  = result_q;
    divzero_d = divzero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = OP;
          acc_d   = '0;
          lo_d    = OP[1] ? DATA1 : DATA2;
          opd_d   = OP[1] ? DATA2 : DATA1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          // MUL_LO/DIV_Q live in lo, MUL_HI/DIV_R live in acc: OP[0] selects.
          result_d  = op_q[0] ? acc_step[WIDTH-1:0] : lo_step;
          divzero_d = op_q[1] && (opd_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      result_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      result_q  <= result_d;
      divzero_q <= divzero_d;
    end
  end

  assign RESULT  = result_q;
  assign DIVZERO = divzero_q;
  assign BUSY    = (state_q == S_CALC);
  assign DONE    = (state_q == S_DONE);

endmodule
